// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// Each operation goes through IDLE -> EXEC -> RESP. Operands are registered
// at acceptance so the ALU sees stable inputs for the whole EXEC cycle, and
// the ALU result and flags are captured at the end of EXEC.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins
// contention). When it is undefined, contention is resolved round-robin.
//
// Handshake semantics (request and response sides alike): a transfer happens
// on a rising clk edge where valid and ready are both 1. reqN_ready is only
// ever asserted in IDLE, for the granted requester. rspN_valid stays high
// with stable data until rspN_ready is seen. Ready may be high before valid.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_lt,
  output logic             rsp_gt,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_gt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic             last_grant;  // requester served most recently
  logic             owner;       // requester of the operation in flight
  logic             grant_vld;
  logic             grant_sel;
  logic             accept;
  logic             rsp_take;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             lt_q;
  logic             gt_q;

  // Grant selection: one valid wins outright; contention goes to the
  // requester that was not served last (or always to requester 0).
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_sel = 1'b0;
`else
      grant_sel = ~last_grant;
`endif
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant_sel = 1'b0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_sel = 1'b1;
    end
  end

  // Ready is suppressed while reset is asserted so no request is acknowledged.
  assign accept     = rst_n && (state == IDLE) && grant_vld;
  assign req0_ready = accept && !grant_sel;
  assign req1_ready = accept && grant_sel;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_lt     = lt_q;
  assign rsp_gt     = gt_q;

  // Operand registers drive the ALU directly and hold between operations.
  assign alu_op    = op_q;
  assign alu_data1 = a_q;
  assign alu_data2 = b_q;

  // Next-state logic for the single-operation-in-flight sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = EXEC;
      EXEC:                  state_next = RESP;
      RESP:    if (rsp_take) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture, result capture and arbitration history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;  // requester 0 wins the first contention
      result_q   <= '0;
      zero_q     <= 1'b0;
      lt_q       <= 1'b0;
      gt_q       <= 1'b0;
    end else begin
      if (accept) begin
        owner <= grant_sel;
        op_q  <= grant_sel ? req1_op : req0_op;
        a_q   <= grant_sel ? req1_a  : req0_a;
        b_q   <= grant_sel ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        // The ALU leaves lt/gt stale on equal operands, so mask them here.
        if (a_q == b_q) begin
          lt_q <= 1'b0;
          gt_q <= 1'b0;
        end else begin
          lt_q <= alu_lt;
          gt_q <= alu_gt;
        end
      end
      if ((state == RESP) && rsp_take) begin
        last_grant <= owner;
      end
    end
  end

endmodule
